incdec_unit: RTL and testbench
==============================

INCDEC_UNIT -- requirements
Module: incdec_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits; multiple of 4, range 8..32.
REQ-002 SHALL have parameter SLICE, default 4, bits processed per cycle; multiple of 4, divides WIDTH, SLICE <= WIDTH.
REQ-003 SHALL have port i_Clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_Reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_Start  input  1  request to begin an operation, sampled on the rising edge.
REQ-006 SHALL have port i_A  input  WIDTH  operand, captured with an accepted start.
REQ-007 SHALL have port i_F  input  4  old flags {Z,N,H,C}, captured with an accepted start.
REQ-008 SHALL have port i_Decrement  input  1  1 = decrement, 0 = increment; captured with start.
REQ-009 SHALL have port i_FlagsEn  input  1  1 = compute new flags, 0 = pass captured i_F through; captured with start.
REQ-010 SHALL have port o_Busy  output  1  operation in progress.
REQ-011 SHALL have port o_Done  output  1  one-cycle pulse; result valid.
REQ-012 SHALL have port o_A  output  WIDTH  result, held until next accepted start.
REQ-013 SHALL have port o_F  output  4  new flags {Z,N,H,C}, held with o_A.
REQ-014 SHALL have port o_Wrap  output  1  carry out of MSB (inc of all-ones or dec of zero), held with o_A.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE; N = WIDTH/SLICE.
REQ-016 SHALL accept i_Start only in IDLE or DONE; i_Start in RUN SHALL be ignored with no effect on the operation in flight.
REQ-017 On accepted start (edge 0): capture operands, clear slice index, carry-in = 1, enter RUN, o_Busy = 1.
REQ-018 In RUN, edges 1..N SHALL each process slice j (bits j*SLICE..j*SLICE+SLICE-1, LSB first): slice + carry-in + (all-ones if decrement), carry-out feeds the next slice.
REQ-019 After edge N: state DONE, o_Busy = 0, o_Done = 1 for exactly one cycle; o_A, o_F, o_Wrap updated at that edge; DONE -> IDLE next edge unless a start is accepted there (back-to-back allowed).
REQ-020 Arithmetic SHALL be modulo 2^WIDTH: 0xFFFF+1 = 0x0000, 0x0000-1 = 0xFFFF (WIDTH=16).
REQ-021 With i_FlagsEn = 1: Z = (result == 0); N = i_Decrement; H = carry out of bit 3 on increment, borrow into bit 3 on decrement (low nybble was 0); C = captured i_F[0] (never modified).
REQ-022 With i_FlagsEn = 0: o_F = captured i_F unchanged.
REQ-023 o_Wrap SHALL equal final MSB carry-out for increment and its inverse for decrement, regardless of i_FlagsEn.
REQ-024 Input changes after capture SHALL NOT affect the result.

Reset
REQ-025 While i_Reset_n = 0: state IDLE, o_Busy = 0, o_Done = 0, o_A = 0, o_F = 0, o_Wrap = 0, internal operand/carry/index cleared.
REQ-026 Reset asserted mid-RUN SHALL abort the operation with no o_Done pulse; first start after release SHALL behave normally.

Structure
REQ-027 Shared package/header incdec_pkg SHALL hold FSM state encodings and flag bit indices (Z=3, N=2, H=1, C=0).
REQ-028 A sub-module incdec_slice (SLICE-bit add with carry-in, decrement mask, carry-out, bit-3 carry tap) SHALL be instantiated once and time-shared across slices.

Verification
REQ-029 WIDTH=16 SLICE=4: inc 0x00FF, FlagsEn=1, i_F=0x1 -> o_Done after edge 4, o_A=0x0100, o_F=0x3, o_Wrap=0.
REQ-030 WIDTH=16: dec 0x0000, FlagsEn=1, i_F=0x0 -> o_A=0xFFFF, o_F=0x6, o_Wrap=1; inc 0xFFFF, i_F=0x0 -> o_A=0x0000, o_F=0xA, o_Wrap=1.
REQ-031 WIDTH=16: inc 0x1234, FlagsEn=0, i_F=0xA -> o_A=0x1235, o_F=0xA, o_Wrap=0.
REQ-032 Second i_Start during RUN with different i_A -> ignored, first result returned; start held high through DONE -> next operation begins without an IDLE cycle.
REQ-033 Reset pulsed at edge 2 of RUN -> all outputs 0, no o_Done; following inc 0x0001 -> o_A=0x0002.
REQ-034 WIDTH=8 SLICE=8: dec 0x10, FlagsEn=1, i_F=0x1 -> o_Done after edge 1, o_A=0x0F, o_F=0x7.

Source files
------------

// File: rtl/incdec_pkg.sv
// Shared definitions for the serial increment/decrement unit.
//   state_t : controller states (idle, running slices, result presented)
//   FLAG_*  : bit positions inside the 4-bit {Z,N,H,C} flag vector
package incdec_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_H = 1;
    localparam int FLAG_C = 0;

endpackage

// File: rtl/incdec_slice.sv
// One SLICE-bit adder step of the serial increment/decrement datapath.
// For a decrement the operand slice is added to all-ones; for an increment
// it is added to zero. The carry in supplies the +1 of the operation.
// Ports:
//   a    : operand slice
//   cin  : adder carry in
//   dec  : 1 = add all-ones mask, 0 = add zero
//   sum  : slice result
//   cout : carry out of the slice MSB
//   c3   : carry out of bit 3 (half-carry tap, meaningful on slice 0)
module incdec_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic             cin,
    input  logic             dec,
    output logic [SLICE-1:0] sum,
    output logic             cout,
    output logic             c3
);

    logic [SLICE:0] full;

    always_comb begin
        full = {1'b0, a} + {1'b0, {SLICE{dec}}} + (SLICE+1)'(cin);
    end

    assign sum  = full[SLICE-1:0];
    assign cout = full[SLICE];

    // Carry into bit 4 is recovered from the sum bit: s4 = a4 ^ m4 ^ c4.
    generate
        if (SLICE == 4) begin : g_c3_top
            assign c3 = full[4];
        end else begin : g_c3_mid
            assign c3 = full[4] ^ a[4] ^ dec;
        end
    endgenerate

endmodule

// File: rtl/incdec_unit.sv
// Multi-cycle increment/decrement unit. The operand is processed SLICE bits
// per clock, LSB first, through one shared incdec_slice, producing a result
// after WIDTH/SLICE run cycles.
// Ports:
//   i_Clk, i_Reset_n : clock, asynchronous active-low reset
//   i_Start          : start request (accepted when not running)
//   i_A, i_F         : operand and old flags {Z,N,H,C}, captured on start
//   i_Decrement      : 1 = decrement, 0 = increment
//   i_FlagsEn        : 1 = compute new flags, 0 = pass i_F through
//   o_Busy           : operation in progress
//   o_Done           : one-cycle pulse, result valid
//   o_A, o_F, o_Wrap : result, flags and MSB wrap, held until next start
module incdec_unit
    import incdec_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             i_Clk,
    input  logic             i_Reset_n,
    input  logic             i_Start,
    input  logic [WIDTH-1:0] i_A,
    input  logic [3:0]       i_F,
    input  logic             i_Decrement,
    input  logic             i_FlagsEn,
    output logic             o_Busy,
    output logic             o_Done,
    output logic [WIDTH-1:0] o_A,
    output logic [3:0]       o_F,
    output logic             o_Wrap
);

    localparam int N     = WIDTH / SLICE;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [WIDTH-1:0]   work;
    logic [3:0]         f_q;
    logic               dec_q;
    logic               fen_q;
    logic               pend;
    logic               h_q;

    logic [SLICE-1:0]   sl_sum;
    logic               sl_cin;
    logic               sl_cout;
    logic               sl_c3;
    logic               pend_next;
    logic               h_tap;
    logic               h_use;
    logic               last;
    logic [WIDTH-1:0]   res_next;
    logic [3:0]         new_f;

    // 'pend' is the pending +1 (increment) or -1 (decrement) still to be
    // propagated. For a decrement the adder sees all-ones plus the inverted
    // pending bit, so a pending borrow becomes cin = 0 and vice versa.
    assign sl_cin    = pend ^ dec_q;
    assign pend_next = sl_cout ^ dec_q;
    assign h_tap     = sl_c3 ^ dec_q;
    assign last      = (idx == IDX_W'(N - 1));
    assign h_use     = (idx == '0) ? h_tap : h_q;

    incdec_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .a    (work[SLICE-1:0]),
        .cin  (sl_cin),
        .dec  (dec_q),
        .sum  (sl_sum),
        .cout (sl_cout),
        .c3   (sl_c3)
    );

    // 'work' holds unprocessed operand bits at the bottom and finished result
    // slices at the top; each step shifts right by one slice.
    generate
        if (SLICE == WIDTH) begin : g_one_slice
            assign res_next = sl_sum;
        end else begin : g_multi_slice
            assign res_next = {sl_sum, work[WIDTH-1:SLICE]};
        end
    endgenerate

    always_comb begin
        new_f = f_q;
        if (fen_q) begin
            new_f[FLAG_Z] = (res_next == '0);
            new_f[FLAG_N] = dec_q;
            new_f[FLAG_H] = h_use;
            new_f[FLAG_C] = f_q[FLAG_C];
        end
    end

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state  <= ST_IDLE;
            idx    <= '0;
            work   <= '0;
            f_q    <= '0;
            dec_q  <= 1'b0;
            fen_q  <= 1'b0;
            pend   <= 1'b0;
            h_q    <= 1'b0;
            o_Busy <= 1'b0;
            o_Done <= 1'b0;
            o_A    <= '0;
            o_F    <= '0;
            o_Wrap <= 1'b0;
        end else begin
            o_Done <= 1'b0;
            case (state)
                ST_RUN: begin
                    // Start requests are ignored while running.
                    work <= res_next;
                    pend <= pend_next;
                    if (idx == '0) begin
                        h_q <= h_tap;
                    end
                    if (last) begin
                        state  <= ST_DONE;
                        idx    <= '0;
                        o_Busy <= 1'b0;
                        o_Done <= 1'b1;
                        o_A    <= res_next;
                        o_F    <= new_f;
                        o_Wrap <= pend_next;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a start; DONE otherwise
                    // falls back to IDLE.
                    if (i_Start) begin
                        state  <= ST_RUN;
                        idx    <= '0;
                        work   <= i_A;
                        f_q    <= i_F;
                        dec_q  <= i_Decrement;
                        fen_q  <= i_FlagsEn;
                        pend   <= 1'b1;
                        h_q    <= 1'b0;
                        o_Busy <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_incdec_unit.sv
// Scoreboard bench for incdec_unit: a 16-bit/4-bit-slice instance and an
// 8-bit/8-bit-slice instance share clock and reset.
module tb_incdec_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    logic        rst_n;
    logic        start16, dec16, fen16, busy16, done16, wrap16;
    logic [15:0] a16, oa16;
    logic [3:0]  f16, of16;
    logic        start8, dec8, fen8, busy8, done8, wrap8;
    logic [7:0]  a8, oa8;
    logic [3:0]  f8, of8;

    typedef struct {
        logic [15:0] a;
        logic [3:0]  f;
        logic        w;
        int          cyc;
    } exp_t;

    exp_t q16[$];
    exp_t q8[$];

    incdec_unit #(.WIDTH(16), .SLICE(4)) u_dut16 (
        .i_Clk(clk), .i_Reset_n(rst_n), .i_Start(start16), .i_A(a16),
        .i_F(f16), .i_Decrement(dec16), .i_FlagsEn(fen16), .o_Busy(busy16),
        .o_Done(done16), .o_A(oa16), .o_F(of16), .o_Wrap(wrap16)
    );

    incdec_unit #(.WIDTH(8), .SLICE(8)) u_dut8 (
        .i_Clk(clk), .i_Reset_n(rst_n), .i_Start(start8), .i_A(a8),
        .i_F(f8), .i_Decrement(dec8), .i_FlagsEn(fen8), .o_Busy(busy8),
        .o_Done(done8), .o_A(oa8), .o_F(of8), .o_Wrap(wrap8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitors: pop and compare on every done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (done16 === 1'b1) begin
            if (q16.size() == 0) begin
                total++; bad++;
                $display("FAIL done16_unexpected: got pulse at cycle %0d expected none", cyc);
            end else begin
                e = q16.pop_front();
                check("a16",    32'(oa16),   32'(e.a));
                check("f16",    32'(of16),   32'(e.f));
                check("wrap16", 32'(wrap16), 32'(e.w));
                check("lat16",  cyc,         e.cyc);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (done8 === 1'b1) begin
            if (q8.size() == 0) begin
                total++; bad++;
                $display("FAIL done8_unexpected: got pulse at cycle %0d expected none", cyc);
            end else begin
                e = q8.pop_front();
                check("a8",    32'(oa8),   32'(e.a));
                check("f8",    32'(of8),   32'(e.f));
                check("wrap8", 32'(wrap8), 32'(e.w));
                check("lat8",  cyc,        e.cyc);
            end
        end
    end

    task automatic drain();
        int n;
        n = 0;
        while ((q16.size() != 0 || q8.size() != 0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", q16.size() + q8.size(), 0);
    endtask

    task automatic op16(input logic [15:0] a, input logic dec, input logic fen,
                        input logic [3:0] f, input logic [15:0] ea,
                        input logic [3:0] ef, input logic ew);
        exp_t e;
        @(negedge clk);
        start16 = 1'b1; a16 = a; dec16 = dec; fen16 = fen; f16 = f;
        e.a = ea; e.f = ef; e.w = ew; e.cyc = cyc + 5;
        q16.push_back(e);
        @(negedge clk);
        // Scramble inputs after capture; the result must not change.
        start16 = 1'b0; a16 = ~a; dec16 = ~dec; fen16 = ~fen; f16 = ~f;
        check("busy16", 32'(busy16), 32'd1);
        drain();
    endtask

    task automatic op8(input logic [7:0] a, input logic dec, input logic fen,
                       input logic [3:0] f, input logic [7:0] ea,
                       input logic [3:0] ef, input logic ew);
        exp_t e;
        @(negedge clk);
        start8 = 1'b1; a8 = a; dec8 = dec; fen8 = fen; f8 = f;
        e.a = 16'(ea); e.f = ef; e.w = ew; e.cyc = cyc + 2;
        q8.push_back(e);
        @(negedge clk);
        start8 = 1'b0; a8 = ~a; dec8 = ~dec; fen8 = ~fen; f8 = ~f;
        drain();
    endtask

    initial begin
        exp_t e;
        int   c0;
        rst_n = 1'b0;
        start16 = 1'b0; a16 = '0; dec16 = 1'b0; fen16 = 1'b0; f16 = '0;
        start8  = 1'b0; a8  = '0; dec8  = 1'b0; fen8  = 1'b0; f8  = '0;
        repeat (3) @(negedge clk);
        check("rst_a16",    32'(oa16),   32'h0);
        check("rst_f16",    32'(of16),   32'h0);
        check("rst_wrap16", 32'(wrap16), 32'h0);
        check("rst_busy16", 32'(busy16), 32'h0);
        check("rst_done16", 32'(done16), 32'h0);
        check("rst_a8",     32'(oa8),    32'h0);
        rst_n = 1'b1;

        //    operand   dec   fen   F      exp A     exp F  wrap
        op16(16'h00FF, 1'b0, 1'b1, 4'h1, 16'h0100, 4'h3, 1'b0);
        op16(16'h0000, 1'b1, 1'b1, 4'h0, 16'hFFFF, 4'h6, 1'b1);
        op16(16'hFFFF, 1'b0, 1'b1, 4'h0, 16'h0000, 4'hA, 1'b1);
        op16(16'h1000, 1'b1, 1'b1, 4'h0, 16'h0FFF, 4'h6, 1'b0);
        op16(16'h000F, 1'b0, 1'b1, 4'h0, 16'h0010, 4'h2, 1'b0);
        op16(16'h1234, 1'b0, 1'b0, 4'hA, 16'h1235, 4'hA, 1'b0);
        repeat (3) @(negedge clk);
        check("hold_a16", 32'(oa16), 32'h1235);
        check("hold_f16", 32'(of16), 32'hA);

        // Start held high: the second request mid-run is ignored, and the
        // one present in DONE starts the next operation immediately.
        @(negedge clk);
        start16 = 1'b1; a16 = 16'h0010; dec16 = 1'b0; fen16 = 1'b1; f16 = 4'h0;
        c0 = cyc;
        e.a = 16'h0011; e.f = 4'h0; e.w = 1'b0; e.cyc = c0 + 5;
        q16.push_back(e);
        @(negedge clk);
        a16 = 16'h7FFF; f16 = 4'h1;
        e.a = 16'h8000; e.f = 4'h3; e.w = 1'b0; e.cyc = c0 + 10;
        q16.push_back(e);
        repeat (5) @(negedge clk);
        start16 = 1'b0; a16 = 16'hDEAD; f16 = 4'hF; dec16 = 1'b1;
        drain();

        // Reset in the middle of a run: no done pulse, outputs cleared.
        @(negedge clk);
        start16 = 1'b1; a16 = 16'h5555; dec16 = 1'b0; fen16 = 1'b1; f16 = 4'h0;
        @(negedge clk);
        start16 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_a16",    32'(oa16),   32'h0);
        check("abort_f16",    32'(of16),   32'h0);
        check("abort_busy16", 32'(busy16), 32'h0);
        check("abort_done16", 32'(done16), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        op16(16'h0001, 1'b0, 1'b0, 4'h5, 16'h0002, 4'h5, 1'b0);

        // Single-slice instance.
        op8(8'h10, 1'b1, 1'b1, 4'h1, 8'h0F, 4'h7, 1'b0);
        op8(8'hFF, 1'b0, 1'b1, 4'h0, 8'h00, 4'hA, 1'b1);

        repeat (5) @(negedge clk);
        check("queues_empty", q16.size() + q8.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
